// File: rtl/enc_defs_pkg.sv
// Shared definitions for the registered priority encoder family.
package enc_defs_pkg;

  localparam logic MODE_FIXED = 1'b0;
  localparam logic MODE_RR    = 1'b1;

endpackage

// File: rtl/priority_pick.sv
// Combinational picker: first set request at or after start, wrapping modulo N.
module priority_pick #(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] start,
  output logic [W-1:0] idx,
  output logic         any,
  output logic         multi
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int unsigned    pos;

  // Rotate so that bit 0 of rot is request 'start'; wrap is on N, not 2^W.
  always_comb begin
    dbl = {req, req};
    rot = N'(dbl >> start);
    idx = '0;
    any = 1'b0;
    pos = 0;
    for (int unsigned k = 0; k < N; k++) begin
      if (!any && rot[k]) begin
        any = 1'b1;
        pos = 32'(start) + k;
        idx = W'((pos >= N) ? (pos - N) : pos);
      end
    end
  end

  assign multi = ($countones(req) > 1);

endmodule

// File: rtl/priority_encoder_rr.sv
// Registered N-input priority encoder with fixed / round-robin policy and valid/ready output.
module priority_encoder_rr
  import enc_defs_pkg::*;
#(
  parameter  int unsigned N = 8,
  localparam int unsigned W = $clog2(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         mode,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] out_idx,
  output logic         out_multi
);

  logic [W-1:0] ptr;
  logic [W-1:0] ptr_inc;
  logic [W-1:0] start;
  logic [W-1:0] pick_idx;
  logic [W-1:0] sel_idx;
  logic [N-1:0] req_rev;
  logic [N-1:0] pick_req;
  logic         pick_any;
  logic         pick_multi;
  logic         load;

  // Fixed priority is a forward search from 0 over the bit-reversed vector.
  always_comb begin
    req_rev = '0;
    for (int unsigned i = 0; i < N; i++) begin
      req_rev[i] = req[N-1-i];
    end
  end

  assign ptr_inc  = (ptr == W'(N-1)) ? '0 : ptr + W'(1);
  assign pick_req = (mode == MODE_RR) ? req : req_rev;
  assign start    = (mode == MODE_RR) ? ptr_inc : '0;

  priority_pick #(.N(N)) u_pick (
    .req   (pick_req),
    .start (start),
    .idx   (pick_idx),
    .any   (pick_any),
    .multi (pick_multi)
  );

  assign sel_idx = (mode == MODE_RR) ? pick_idx : (W'(N-1) - pick_idx);
  assign load    = pick_any && (!out_valid || out_ready);

  // Output stage and round-robin pointer; an unaccepted result holds until out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_idx   <= '0;
      out_multi <= 1'b0;
      ptr       <= W'(N-1);
    end else if (load) begin
      out_valid <= 1'b1;
      out_idx   <= sel_idx;
      out_multi <= pick_multi;
      ptr       <= sel_idx;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_priority_encoder_rr.sv
// Directed, table-driven bench for priority_encoder_rr (N=8 and N=5 instances).
module tb_priority_encoder_rr;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] req8 = '0;
  logic       mode8 = 1'b0;
  logic       ready8 = 1'b0;
  logic       valid8;
  logic [2:0] idx8;
  logic       multi8;
  logic [4:0] req5 = '0;
  logic       mode5 = 1'b0;
  logic       ready5 = 1'b0;
  logic       valid5;
  logic [2:0] idx5;
  logic       multi5;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [7:0] req;
    logic       mode;
    logic       ready;
    logic       ev;
    logic [2:0] ei;
    logic       em;
  } vec_t;

  vec_t tbl[$];

  always #5 clk = ~clk;

  priority_encoder_rr #(.N(8)) u_dut8 (
    .clk       (clk),
    .rst       (rst),
    .req       (req8),
    .mode      (mode8),
    .out_ready (ready8),
    .out_valid (valid8),
    .out_idx   (idx8),
    .out_multi (multi8)
  );

  priority_encoder_rr #(.N(5)) u_dut5 (
    .clk       (clk),
    .rst       (rst),
    .req       (req5),
    .mode      (mode5),
    .out_ready (ready5),
    .out_valid (valid5),
    .out_idx   (idx5),
    .out_multi (multi5)
  );

  task automatic add(input logic [7:0] r, input logic m, input logic rd,
                     input logic ev, input logic [2:0] ei, input logic em);
    vec_t v;
    v.req = r; v.mode = m; v.ready = rd; v.ev = ev; v.ei = ei; v.em = em;
    tbl.push_back(v);
  endtask

  task automatic check_out(input string name, input logic av, input logic [2:0] ai,
                           input logic am, input logic ev, input logic [2:0] ei,
                           input logic em);
    checks++;
    if (av !== ev) begin
      errors++;
      $display("FAIL %s valid: got %0b want %0b", name, av, ev);
    end
    checks++;
    if (ai !== ei) begin
      errors++;
      $display("FAIL %s idx: got %0d want %0d", name, ai, ei);
    end
    checks++;
    if (am !== em) begin
      errors++;
      $display("FAIL %s multi: got %0b want %0b", name, am, em);
    end
  endtask

  initial begin
    // Fixed one-hot sweep.
    for (int i = 0; i < 8; i++) add(8'(1 << i), 1'b0, 1'b1, 1'b1, 3'(i), 1'b0);
    // Fixed multi-hot.
    add(8'b0000_0110, 1'b0, 1'b1, 1'b1, 3'd2, 1'b1);
    add(8'b1000_0001, 1'b0, 1'b1, 1'b1, 3'd7, 1'b1);
    // Round-robin rotation over all-ones, starting after ptr = 7.
    for (int i = 0; i < 9; i++) add(8'hFF, 1'b1, 1'b1, 1'b1, 3'(i % 8), 1'b1);
    // Round-robin between bits 2 and 5.
    add(8'b0010_0100, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1);
    add(8'b0010_0100, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1);
    add(8'b0010_0100, 1'b1, 1'b1, 1'b1, 3'd2, 1'b1);
    add(8'b0010_0100, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1);
    // Backpressure: idx 3 held while req/mode wander.
    add(8'h08, 1'b0, 1'b1, 1'b1, 3'd3, 1'b0);
    add(8'hFF, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
    add(8'h01, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    add(8'h00, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
    add(8'h81, 1'b0, 1'b0, 1'b1, 3'd3, 1'b0);
    // Accept edge loads the current req; then an empty req drops valid.
    add(8'h60, 1'b0, 1'b1, 1'b1, 3'd6, 1'b1);
    add(8'h00, 1'b0, 1'b1, 1'b0, 3'd6, 1'b1);
    add(8'h00, 1'b0, 1'b0, 1'b0, 3'd6, 1'b1);
    // Idle output loads regardless of out_ready.
    add(8'h10, 1'b0, 1'b0, 1'b1, 3'd4, 1'b0);
    // Pointer followed the fixed-mode result (4), so round-robin resumes at 5.
    add(8'hFF, 1'b1, 1'b1, 1'b1, 3'd5, 1'b1);
    add(8'hFF, 1'b1, 1'b1, 1'b1, 3'd6, 1'b1);

    #2 rst = 1'b1;
    #1 check_out("reset_idle", valid8, idx8, multi8, 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b0;

    foreach (tbl[n]) begin
      req8   = tbl[n].req;
      mode8  = tbl[n].mode;
      ready8 = tbl[n].ready;
      @(posedge clk);
      #1 check_out($sformatf("vec%0d", n), valid8, idx8, multi8,
                   tbl[n].ev, tbl[n].ei, tbl[n].em);
    end

    // Reset with a pending, unaccepted result: clears without a clock edge.
    ready8 = 1'b0;
    rst    = 1'b1;
    #1 check_out("reset_busy", valid8, idx8, multi8, 1'b0, 3'd0, 1'b0);
    #2 rst = 1'b0;
    req8   = 8'hFF;
    mode8  = 1'b1;
    ready8 = 1'b1;
    @(posedge clk);
    #1 check_out("rr_after_reset", valid8, idx8, multi8, 1'b1, 3'd0, 1'b1);
    req8 = 8'h00;

    // Non-power-of-two wrap on the N=5 instance.
    req5   = 5'b10001;
    mode5  = 1'b1;
    ready5 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1 check_out($sformatf("n5_step%0d", i), valid5, idx5, multi5,
                   1'b1, (i % 2 == 0) ? 3'd0 : 3'd4, 1'b1);
      checks++;
      if (idx5 > 3'd4) begin
        errors++;
        $display("FAIL n5_range%0d: got %0d want <5", i, idx5);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/priority_encoder_rr.md
# priority_encoder_rr

Parametrised N-input registered priority encoder, the successor to the fixed 8-to-3 combinational encoder. It samples a request vector and registers the index of the selected request, with a selectable fixed-priority or round-robin policy. It flags when more than one request was high, which the combinational encoder leaves undefined. A valid/ready output stage lets downstream logic apply backpressure. It sits between request sources (interrupt lines, channel flags) and a single consumer of encoded indices.

## Interface
- N, 8, number of request inputs; legal N ≥ 2, any integer (not restricted to powers of two)
- W, $clog2(N), index width; derived, not overridden
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- req  input  N  request levels; bit i = request i
- mode  input  1  0 = fixed priority (highest index wins), 1 = round-robin
- out_ready  input  1  consumer accepts current output
- out_valid  output  1  out_idx/out_multi hold a valid result
- out_idx  output  W  index of the selected request
- out_multi  output  1  more than one req bit was high at the sample

## Operation
- Load enable: load = req != 0 && (!out_valid || out_ready).
- On load, the block registers:
  - out_idx = selected index
  - out_multi = (popcount(req) > 1)
  - out_valid = 1
  - ptr = selected index
- When out_valid && out_ready && req == 0, out_valid clears to 0. out_idx and out_multi keep their last values.
- When out_valid && !out_ready, the outputs hold stable. Changes on req and mode are ignored.
- Fixed mode: select the highest set bit of req. ptr still updates.
- Round-robin mode: search order is ptr+1, ptr+2, …, N-1, 0, …, ptr, and the first set bit wins. ptr+1 wraps from N-1 to 0. This works for non-power-of-two N; modulo is on N, not 2^W.
- mode is sampled only at load. Switching mode does not reset ptr.
- All-zero req never loads. No index is reported for an empty vector.
- Reset values:
  - out_valid = 0
  - out_idx = 0
  - out_multi = 0
  - ptr = N-1, so the first round-robin search starts at index 0

## Timing
- Latency: req sampled at edge k appears on the outputs after edge k (one cycle). There is no combinational path from req to the outputs.
- Throughput: one result per cycle while out_ready = 1 and req ≠ 0.
- Handshake: a transfer occurs on an edge where out_valid && out_ready. A new result may load on that same edge, giving back-to-back operation with no bubble.
- Holding: out_idx and out_multi must not change while out_valid = 1 and out_ready = 0.
- Reset: assertion clears all state immediately, without waiting for a clock edge. Deassertion is synchronous to clk upstream. The first possible load is the first rising edge with rst = 0.
- Reset mid-transfer: a pending, unaccepted result is discarded.

## Structure
- Shared package/include enc_defs holds:
  - mode encodings MODE_FIXED = 1'b0 and MODE_RR = 1'b1
  - a clog2 helper, if the toolflow lacks $clog2
- Sub-module priority_pick (combinational):
  - inputs: req[N], start[W]
  - outputs: idx[W], any, multi
  - returns the first set bit at or after start, wrapping modulo N
- The top level computes the start index from mode and ptr:
  - fixed mode: implemented as a reversed-order search, or a second instance searching downward from N-1
  - round-robin mode: start = ptr+1 mod N
- Top level owns the output register, ptr and handshake logic.

## Test plan
- Reset: assert rst while idle and again while out_valid = 1 → out_valid = 0, out_idx = 0, out_multi = 0 immediately, without a clock edge. The next round-robin result with req = 8'hFF is idx 0.
- Fixed one-hot sweep (N = 8, mode = 0, out_ready = 1): req = 8'h01, 8'h02, …, 8'h80, one per cycle → out_idx = 0..7 one cycle later, out_multi = 0, out_valid continuously 1.
- Fixed multi-hot: req = 8'b00000110 → out_idx = 2, out_multi = 1. Then req = 8'b10000001 → out_idx = 7, out_multi = 1.
- Round-robin rotation: mode = 1, req = 8'hFF held, out_ready = 1 → out_idx = 0,1,2,…,7,0. Then req = 8'b00100100 → out_idx = 2, 5, 2, 5.
- Backpressure: result idx = 3 valid, out_ready = 0 for 4 cycles while req toggles → out_idx = 3 and out_multi held stable. When out_ready = 1 for one cycle, the current req loads on that edge. With req = 0 at that edge, out_valid drops to 0.
- Non-power-of-two wrap: N = 5, mode = 1, req = 5'b10001 → out_idx = 0, 4, 0, 4. Index 5–7 never appears.
